// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the integer register file.
// Arbitrates N_REQ writeback requesters round-robin onto a single registered
// register-file write port and keeps a pending-write scoreboard (busy) that
// stalls issue of instructions touching a register with an outstanding write.
//
// Handshake: a writeback from requester i is accepted in the cycle where
// wb_valid[i] and wb_ready[i] are both high. wb_ready is one-hot (or zero),
// combinational, and may depend on wb_valid; a requester must hold its
// rd/data stable until accepted. Acceptance is the only event that moves
// the round-robin pointer.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rs1,
    input  logic [4:0]                 issue_rs2,
    input  logic [4:0]                 issue_rd,
    output logic                       issue_stall,
    input  logic [N_REQ-1:0]           wb_valid,
    input  logic [5*N_REQ-1:0]         wb_rd,
    input  logic [DATA_W*N_REQ-1:0]    wb_data,
    output logic [N_REQ-1:0]           wb_ready,
    output logic                       rf_reg_write,
    output logic [4:0]                 rf_rd,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [31:0]                busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // rr_ptr_q names the requester with highest priority this cycle.
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]       busy_q, busy_d;
    logic              rf_reg_write_q, rf_reg_write_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;

    logic [N_REQ-1:0]  grant;
    logic              acc_found;
    logic [PTR_W-1:0]  acc_idx;
    logic [4:0]        acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic              issue_fire;

    // Round-robin search starting at rr_ptr_q, wrapping past N_REQ-1 to 0.
    always_comb begin
        int cand;
        grant     = '0;
        acc_found = 1'b0;
        acc_idx   = '0;
        acc_rd    = '0;
        acc_data  = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!acc_found && wb_valid[cand]) begin
                acc_found   = 1'b1;
                grant[cand] = 1'b1;
                acc_idx     = cand[PTR_W-1:0];
                acc_rd      = wb_rd[5*cand +: 5];
                acc_data    = wb_data[DATA_W*cand +: DATA_W];
            end
        end
    end

    assign wb_ready = grant;

    // Stall looks only at the registered scoreboard; a clear landing this
    // cycle is not forwarded, so the instruction issues one cycle later.
    assign issue_stall = issue_valid &&
                         (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
    assign issue_fire  = issue_valid && !issue_stall && (issue_rd != 5'd0);

    // Next-state: pointer, scoreboard (issue set wins over writeback clear), write port.
    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        busy_d          = busy_q;
        rf_reg_write_d  = 1'b0;
        rf_rd_d         = rf_rd_q;
        rf_write_data_d = rf_write_data_q;
        if (acc_found) begin
            if (acc_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = acc_idx + 1'b1;
            end
            if (acc_rd != 5'd0) begin
                busy_d[acc_rd]  = 1'b0;
                rf_reg_write_d  = 1'b1;
                rf_rd_d         = acc_rd;
                rf_write_data_d = acc_data;
            end
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset clears the scoreboard and drops any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q        <= '0;
            busy_q          <= '0;
            rf_reg_write_q  <= 1'b0;
            rf_rd_q         <= '0;
            rf_write_data_q <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            busy_q          <= busy_d;
            rf_reg_write_q  <= rf_reg_write_d;
            rf_rd_q         <= rf_rd_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_write_data_q;
    assign busy          = busy_q;

endmodule
